adder_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one WIDTH-bit ripple-carry adder datapath among NREQ requesters. Example requesters: counters, accumulators.
- Each requester presents two operands and a carry-in under a req/ack handshake.
- The block latches the winning request, runs it through the shared adder, and returns the registered sum and carry-out with a one-cycle ack to the winner.
- Replaces one private adder per counter when area is tight.

---
 rtl/adder_share_arb.sv | 162 ++++++++++++++++
 tb/tb_adder_share_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one ripple-carry adder among NREQ requesters.
// A winner is latched in IDLE, added in BUSY, and acked with a registered sum/carry.
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] op_a_i,
    input  logic [NREQ*WIDTH-1:0] op_b_i,
    input  logic [NREQ-1:0]       cin_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [NREQ-1:0]       grant_o,
    output logic [WIDTH-1:0]      sum_o,
    output logic                  cout_o,
    output logic                  res_valid_o,
    output logic                  busy_o
);

    // state | meaning
    // IDLE  | arbitrate among eligible requesters, latch winner's operands
    // BUSY  | shared adder evaluates latched operands, result registered at edge

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              cin_q, cin_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [NREQ-1:0]   elig;
    logic              found;
    logic [PW-1:0]     win_idx;
    logic [WIDTH-1:0]  a_sel, b_sel;
    logic              cin_sel;
    logic [WIDTH:0]    carry;
    logic [WIDTH-1:0]  add_sum;

    // The just-acked requester is masked so a stale req is never served twice.
    always_comb begin
        elig    = req_i & ~ack_q;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i] && (i >= int'(rr_ptr_q))) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i]) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                a_sel   = op_a_i[i*WIDTH +: WIDTH];
                b_sel   = op_b_i[i*WIDTH +: WIDTH];
                cin_sel = cin_i[i];
            end
        end
    end

    always_comb begin
        carry    = '0;
        add_sum  = '0;
        carry[0] = cin_q;
        for (int i = 0; i < WIDTH; i++) begin
            add_sum[i]  = a_q[i] ^ b_q[i] ^ carry[i];
            carry[i+1]  = (a_q[i] & b_q[i]) | (carry[i] & (a_q[i] ^ b_q[i]));
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        grant_d     = grant_q;
        ack_d       = '0;
        res_valid_d = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    cin_d   = cin_sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d       = add_sum;
                cout_d      = carry[WIDTH];
                ack_d       = grant_q;
                res_valid_d = 1'b1;
                rr_ptr_d    = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
                grant_d     = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
        end
    end

    assign ack_o       = ack_q;
    assign grant_o     = grant_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = (state_q == BUSY);

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: reset, single ops, carry, round-robin,
// self-masking counter, operand change after grant and mid-operation reset.
module tb_adder_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  cin;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [3:0]  sum;
    logic        cout;
    logic        res_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int a_err  = 0;

    adder_share_arb #(.NREQ(4), .WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .cin_i       (cin),
        .ack_o       (ack),
        .grant_o     (grant),
        .sum_o       (sum),
        .cout_o      (cout),
        .res_valid_o (res_valid),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            assert ($onehot0(grant)) else begin
                a_err++;
                $error("FAIL grant_onehot: observed %b required at most one bit set", grant);
            end
            assert ($onehot0(ack)) else begin
                a_err++;
                $error("FAIL ack_onehot: observed %b required at most one bit set", ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_ack, input logic [3:0] e_grant,
                              input logic [3:0] e_sum, input logic e_cout, input logic e_rv,
                              input logic e_busy);
        chk({tag, ".ack"},       32'(ack),       32'(e_ack));
        chk({tag, ".grant"},     32'(grant),     32'(e_grant));
        chk({tag, ".sum"},       32'(sum),       32'(e_sum));
        chk({tag, ".cout"},      32'(cout),      32'(e_cout));
        chk({tag, ".res_valid"}, 32'(res_valid), 32'(e_rv));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    endtask

    initial begin
        logic [4:0] exp5;
        logic [3:0] cnt;
        int         waited;
        logic       got;

        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        cin   = '0;
        #12;
        check_outs("reset", 4'b0, 4'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("idle", 4'b0, 4'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // single request from requester 0
        req = 4'b0001; op_a[3:0] = 4'h3; op_b[3:0] = 4'h4; cin[0] = 1'b0;
        tick();
        check_outs("single_grant", 4'b0, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("single_ack", 4'b0001, 4'b0, 4'h7, 1'b0, 1'b1, 1'b0);
        req = 4'b0;
        tick();
        check_outs("single_hold", 4'b0, 4'b0, 4'h7, 1'b0, 1'b0, 1'b0);

        // wrap and carry on requester 2
        req = 4'b0100; op_a[11:8] = 4'hF; op_b[11:8] = 4'h1; cin[2] = 1'b1;
        tick();
        check_outs("wrap_grant", 4'b0, 4'b0100, 4'h7, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wrap_ack", 4'b0100, 4'b0, 4'h1, 1'b1, 1'b1, 1'b0);
        op_a[11:8] = 4'h8; op_b[11:8] = 4'h8; cin[2] = 1'b0;
        tick();
        check_outs("wrap_mask", 4'b0, 4'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("wrap2_grant", 4'b0, 4'b0100, 4'h1, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("wrap2_ack", 4'b0100, 4'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        req = 4'b0;

        // operands change and req drops after grant on requester 3
        req = 4'b1000; op_a[15:12] = 4'h2; op_b[15:12] = 4'h3; cin[3] = 1'b0;
        tick();
        check_outs("chg_grant", 4'b0, 4'b1000, 4'h0, 1'b1, 1'b0, 1'b1);
        op_a[15:12] = 4'h9; req = 4'b0;
        tick();
        check_outs("chg_ack", 4'b1000, 4'b0, 4'h5, 1'b0, 1'b1, 1'b0);

        // asynchronous reset while BUSY
        req = 4'b0010; op_a[7:4] = 4'h1; op_b[7:4] = 4'h1; cin[1] = 1'b0;
        tick();
        check_outs("pre_rst_grant", 4'b0, 4'b0010, 4'h5, 1'b0, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0, 4'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        req = 4'b0;
        #3 rst_n = 1'b1;
        tick();
        check_outs("post_rst1", 4'b0, 4'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("post_rst2", 4'b0, 4'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // round-robin with all four requesting continuously; sum = index + 1
        for (int i = 0; i < 4; i++) begin
            op_a[i*4 +: 4] = 4'(i);
            op_b[i*4 +: 4] = 4'h1;
        end
        cin = 4'b0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs("rr_grant", 4'b0, 4'b0001 << (k % 4),
                       (k == 0) ? 4'h0 : 4'(((k - 1) % 4) + 1), 1'b0, 1'b0, 1'b1);
            tick();
            check_outs("rr_ack", 4'b0001 << (k % 4), 4'b0, 4'((k % 4) + 1), 1'b0, 1'b1, 1'b0);
        end
        req = 4'b0;
        tick();
        check_outs("rr_drain", 4'b0, 4'b0, 4'h4, 1'b0, 1'b0, 1'b0);

        // requester 1 as a free-running 4-bit counter
        cnt = 4'h0;
        op_a[7:4] = cnt; op_b[7:4] = 4'h1; cin[1] = 1'b0;
        req = 4'b0010;
        for (int n = 0; n < 16; n++) begin
            waited = 0;
            got    = 1'b0;
            while (!got && waited < 6) begin
                tick();
                waited++;
                if (ack[1] === 1'b1) got = 1'b1;
            end
            exp5 = {1'b0, cnt} + 5'd1;
            chk("cnt_latency",   32'(waited),    (n == 0) ? 32'd2 : 32'd3);
            chk("cnt_ack",       32'(ack),       32'h2);
            chk("cnt_sum",       32'(sum),       32'(exp5[3:0]));
            chk("cnt_cout",      32'(cout),      32'(exp5[4]));
            chk("cnt_res_valid", 32'(res_valid), 32'h1);
            cnt = exp5[3:0];
            op_a[7:4] = cnt;
        end
        req = 4'b0;
        tick();
        tick();
        check_outs("final_idle", 4'b0, 4'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors + a_err);
        $finish;
    end

endmodule
